// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM states, owner codes and
// the byte-enable used for instruction fetches.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_DATA  = 1'b0,
    ARB_OWN_FETCH = 1'b1
  } arb_owner_e;

  // Fetches always read a full word.
  localparam logic [3:0] ARB_FETCH_BE = 4'hF;

endpackage

// File: rtl/arb_timer.sv
// Transaction watchdog: cleared on capture, counts while enabled and flags the
// cycle in which TIMEOUT_CYCLES cycles have elapsed since capture.
module arb_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The counter holds elapsed-cycles minus one, so the final cycle matches here.
  assign expired_o = en_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one memory bus between the data load/store path and instruction
// fetch. One transaction in flight at a time; responses are routed to the
// owner, stale fetch responses are dropped after a flush, and a watchdog aborts
// transactions the slave never answers.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants on collisions
// instead of fixed data priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic [3:0]        d_be_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_err_o,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic              i_flush_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [3:0]        bus_be_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              stallreq_o
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic              drop_q, drop_d;
`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_e        last_q, last_d;
`endif

  logic pick_fetch;
  logic grant_d, grant_i;
  logic resp_valid, resp_err;
  logic timer_clr, timer_en, timer_expired;
  logic fetch_stale;

  arb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clr_i    (timer_clr),
    .en_i     (timer_en),
    .expired_o(timer_expired)
  );

  assign timer_en = (state_q != ARB_IDLE);

  // Winner selection for a capture in IDLE.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    pick_fetch = i_req_i && (!d_req_i || (last_q == ARB_OWN_DATA));
`else
    pick_fetch = i_req_i && !d_req_i;
`endif
  end

  // FSM next state, capture of the bus request and response qualification.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    drop_d      = drop_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    grant_d     = 1'b0;
    grant_i     = 1'b0;
    resp_valid  = 1'b0;
    resp_err    = 1'b0;
    timer_clr   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (d_req_i || i_req_i) begin
          if (pick_fetch) begin
            grant_i     = 1'b1;
            owner_d     = ARB_OWN_FETCH;
            bus_we_d    = 1'b0;
            bus_addr_d  = i_addr_i;
            bus_wdata_d = '0;
            bus_be_d    = ARB_FETCH_BE;
          end else begin
            grant_d     = 1'b1;
            owner_d     = ARB_OWN_DATA;
            bus_we_d    = d_we_i;
            bus_addr_d  = d_addr_i;
            bus_wdata_d = d_wdata_i;
            bus_be_d    = d_be_i;
          end
`ifdef ARB_ROUND_ROBIN_EN
          last_d    = owner_d;
`endif
          timer_clr = 1'b1;
          bus_req_d = 1'b1;
          state_d   = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (timer_expired) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
          bus_req_d  = 1'b0;
          state_d    = ARB_IDLE;
        end else if (bus_gnt_i) begin
          bus_req_d = 1'b0;
          state_d   = ARB_RESP;
        end
      end
      ARB_RESP: begin
        // A response arriving on the expiry cycle still counts as normal.
        if (bus_rvalid_i) begin
          resp_valid = 1'b1;
          state_d    = ARB_IDLE;
        end else if (timer_expired) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
          state_d    = ARB_IDLE;
        end
      end
      default: begin
        bus_req_d = 1'b0;
        state_d   = ARB_IDLE;
      end
    endcase

    if ((state_q != ARB_IDLE) && (owner_q == ARB_OWN_FETCH) && i_flush_i) begin
      drop_d = 1'b1;
    end
    if (state_d == ARB_IDLE) begin
      drop_d = 1'b0;
    end
  end

  // State and bus request registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_OWN_DATA;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      drop_q      <= drop_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-granted master, used only to break ties.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q <= ARB_OWN_FETCH;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // A flush in the response cycle itself already makes the fetch stale.
  assign fetch_stale = drop_q || i_flush_i;

  // Grants and stall are gated by reset so outputs read 0 while it is held.
  assign d_gnt_o    = rst_n_i && grant_d;
  assign i_gnt_o    = rst_n_i && grant_i;

  assign d_rvalid_o = resp_valid && (owner_q == ARB_OWN_DATA);
  assign d_err_o    = d_rvalid_o && resp_err;
  assign d_rdata_o  = (d_rvalid_o && !resp_err) ? bus_rdata_i : '0;

  assign i_rvalid_o = resp_valid && (owner_q == ARB_OWN_FETCH) && !fetch_stale;
  assign i_err_o    = i_rvalid_o && resp_err;
  assign i_rdata_o  = (i_rvalid_o && !resp_err) ? bus_rdata_i : '0;

  // The request is withdrawn in the cycle the watchdog fires.
  assign bus_req_o   = bus_req_q && !timer_expired;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_be_o    = bus_be_q;

  assign stallreq_o = rst_n_i &&
                      ((d_req_i && !d_gnt_o) ||
                       ((state_q != ARB_IDLE) && (owner_q == ARB_OWN_DATA) && !d_rvalid_o));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int unsigned TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        d_req_i = 1'b0, d_we_i = 1'b0;
  logic [31:0] d_addr_i = '0, d_wdata_i = '0;
  logic [3:0]  d_be_i = '0;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic        i_req_i = 1'b0, i_flush_i = 1'b0;
  logic [31:0] i_addr_i = '0;
  logic        i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] i_rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        stallreq_o;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .d_err_o(d_err_o),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_flush_i(i_flush_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .stallreq_o(stallreq_o)
  );

  always #5 clk_i = ~clk_i;

  // flags order: d_gnt d_rvalid d_err i_gnt i_rvalid i_err bus_req stall
  typedef struct {
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_flush;
    logic        bgnt;
    logic        brv;
    logic [31:0] brdata;
    logic [7:0]  flags;
    logic [31:0] rdata;
    logic [31:0] baddr;
    logic        bwe;
    logic [3:0]  bbe;
  } vec_t;

  function automatic logic [71:0] outs();
    return {d_gnt_o, d_rvalid_o, d_err_o, i_gnt_o, i_rvalid_o, i_err_o,
            bus_req_o, stallreq_o, d_rdata_o, i_rdata_o};
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr_inputs();
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0; d_be_i = '0;
    i_req_i = 1'b0; i_addr_i = '0; i_flush_i = 1'b0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
  endtask

  // Advance to 1 time unit after the next active edge; inputs change here.
  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle before sampling (well ahead of the edge).
  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  // Transaction-level reference: per-cycle expected outputs from the rules.
  task automatic run_random(input int unsigned ncyc);
    bit          busy = 1'b0, accepted = 1'b0, own_f = 1'b0, dropped = 1'b0;
    bit          last_f = 1'b1;
    bit          rr;
    int unsigned age = 0;
    int unsigned p = 60;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic        m_we = 1'b0;
    logic [3:0]  m_be = '0;
`ifdef ARB_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    for (int unsigned c = 0; c < ncyc; c++) begin
      bit e_dg, e_ig, e_dv, e_de, e_iv, e_ie, e_br, e_st, win_f, done, err;
      logic [31:0] e_dd, e_id;
      if (c % 64 == 0) p = ($urandom_range(0, 1) == 0) ? 60 : 10;
      d_req_i      = ($urandom_range(0, 99) < 40);
      d_we_i       = $urandom_range(0, 1) == 1;
      d_addr_i     = $urandom;
      d_wdata_i    = $urandom;
      d_be_i       = 4'($urandom_range(0, 15));
      i_req_i      = ($urandom_range(0, 99) < 40);
      i_addr_i     = $urandom;
      i_flush_i    = ($urandom_range(0, 99) < 10);
      bus_gnt_i    = ($urandom_range(0, 99) < p);
      bus_rvalid_i = ($urandom_range(0, 99) < p);
      bus_rdata_i  = $urandom;

      {e_dg, e_ig, e_dv, e_de, e_iv, e_ie, e_br} = '0;
      e_dd = '0; e_id = '0; done = 1'b0; err = 1'b0; win_f = 1'b0;
      if (!busy) begin
        win_f = i_req_i && (!d_req_i || (rr && !last_f));
        if (d_req_i || i_req_i) begin
          e_dg = !win_f;
          e_ig = win_f;
        end
      end else begin
        if (!accepted) begin
          e_br = (age != TO);
          done = (age == TO);
          err  = done;
        end else if (bus_rvalid_i) begin
          done = 1'b1;
        end else if (age == TO) begin
          done = 1'b1;
          err  = 1'b1;
        end
        if (done && !own_f) begin
          e_dv = 1'b1; e_de = err; e_dd = err ? 32'h0 : bus_rdata_i;
        end
        if (done && own_f && !(dropped || i_flush_i)) begin
          e_iv = 1'b1; e_ie = err; e_id = err ? 32'h0 : bus_rdata_i;
        end
      end
      e_st = (d_req_i && !e_dg) || (busy && !own_f && !e_dv);

      settle();
      chk($sformatf("rand_c%0d", c), 96'(outs()),
          96'({e_dg, e_dv, e_de, e_ig, e_iv, e_ie, e_br, e_st, e_dd, e_id}));
      if (busy && !accepted && e_br) begin
        chk($sformatf("rand_bus_c%0d", c), 96'({bus_addr_o, bus_we_o, bus_be_o}),
            96'({m_addr, m_we, m_be}));
        if (!own_f) chk($sformatf("rand_wd_c%0d", c), 96'(bus_wdata_o), 96'(m_wdata));
      end

      if (!busy) begin
        if (d_req_i || i_req_i) begin
          busy = 1'b1; accepted = 1'b0; age = 1; own_f = win_f; dropped = 1'b0;
          last_f = win_f;
          m_addr  = win_f ? i_addr_i : d_addr_i;
          m_we    = win_f ? 1'b0 : d_we_i;
          m_be    = win_f ? 4'hF : d_be_i;
          m_wdata = d_wdata_i;
        end
      end else begin
        if (own_f && i_flush_i) dropped = 1'b1;
        if (done) begin
          busy = 1'b0;
        end else begin
          if (!accepted && bus_gnt_i) accepted = 1'b1;
          age++;
        end
      end
      nxt();
    end
    clr_inputs();
  endtask

  vec_t vt[19];

  initial begin
    vt = '{
      //  dreq  dwe   daddr         dwdata        dbe    ireq  iaddr         flush gnt   rv    brdata        flags          rdata         baddr         bwe   bbe
      '{1'b1, 1'b0, 32'h0000_0100, 32'h0,        4'hF, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        8'b1000_0000, 32'h0,        32'h0,        1'b0, 4'h0},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        8'b0000_0011, 32'h0,        32'h0000_0100, 1'b0, 4'hF},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        8'b0000_0001, 32'h0,        32'h0,        1'b0, 4'h0},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 8'b0100_0000, 32'hDEAD_BEEF, 32'h0,        1'b0, 4'h0},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        8'b0000_0000, 32'h0,        32'h0,        1'b0, 4'h0},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'h0,        8'b0001_0000, 32'h0,        32'h0,        1'b0, 4'h0},
      '{1'b1, 1'b0, 32'h0000_0999, 32'h0,        4'hF, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        8'b0000_0011, 32'h0,        32'h0000_0200, 1'b0, 4'hF},
      '{1'b1, 1'b0, 32'h0000_0999, 32'h0,        4'hF, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        8'b0000_0001, 32'h0,        32'h0,        1'b0, 4'h0},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0013, 8'b0000_0000, 32'h0,        32'h0,        1'b0, 4'h0},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 1'b0, 32'h0,        8'b0001_0000, 32'h0,        32'h0,        1'b0, 4'h0},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        8'b0000_0010, 32'h0,        32'h0000_0300, 1'b0, 4'hF},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0050_0093, 8'b0000_1000, 32'h0050_0093, 32'h0,        1'b0, 4'h0},
      '{1'b1, 1'b1, 32'h0000_0044, 32'h0000_CAFE, 4'h3, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        8'b1000_0000, 32'h0,        32'h0,        1'b0, 4'h0},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        8'b0000_0011, 32'h0,        32'h0000_0044, 1'b1, 4'h3},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0055, 8'b0100_0000, 32'h0000_0055, 32'h0,        1'b0, 4'h0},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,        8'b0000_0000, 32'h0,        32'h0,        1'b0, 4'h0},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 32'h0,        8'b0001_0000, 32'h0,        32'h0,        1'b0, 4'h0},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        8'b0000_0010, 32'h0,        32'h0000_0400, 1'b0, 4'hF},
      '{1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0000_0077, 8'b0000_1000, 32'h0000_0077, 32'h0,        1'b0, 4'h0}
    };

    // Reset state, with both requesters active while reset is held.
    clr_inputs();
    d_req_i = 1'b1; i_req_i = 1'b1;
    #12;
    chk("reset_outs", 96'(outs()), 96'h0);
    chk("reset_bus", 96'({bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o}), 96'h0);
    do_reset();

    // Directed vector table, one row per cycle.
    for (int r = 0; r < 19; r++) begin
      d_req_i = vt[r].d_req; d_we_i = vt[r].d_we; d_addr_i = vt[r].d_addr;
      d_wdata_i = vt[r].d_wdata; d_be_i = vt[r].d_be;
      i_req_i = vt[r].i_req; i_addr_i = vt[r].i_addr; i_flush_i = vt[r].i_flush;
      bus_gnt_i = vt[r].bgnt; bus_rvalid_i = vt[r].brv; bus_rdata_i = vt[r].brdata;
      settle();
      chk($sformatf("vec%0d", r), 96'(outs()),
          96'({vt[r].flags, vt[r].flags[6] ? vt[r].rdata : 32'h0,
               vt[r].flags[3] ? vt[r].rdata : 32'h0}));
      if (vt[r].flags[1])
        chk($sformatf("vec%0d_bus", r), 96'({bus_addr_o, bus_we_o, bus_be_o}),
            96'({vt[r].baddr, vt[r].bwe, vt[r].bbe}));
      if (r == 13) chk("vec13_wdata", 96'(bus_wdata_o), 96'h0000_CAFE);
      nxt();
    end
    clr_inputs();

    // Timeout with the slave never granting.
    d_req_i = 1'b1; d_addr_i = 32'h500; d_be_i = 4'hF;
    settle();
    chk("to_capture", 96'(d_gnt_o), 96'h1);
    nxt();
    d_req_i = 1'b0; bus_rdata_i = 32'hFFFF_FFFF;
    for (int k = 1; k <= 16; k++) begin
      settle();
      if (k < 16) begin
        chk($sformatf("to_wait%0d", k), 96'({d_rvalid_o, d_err_o, bus_req_o, stallreq_o}), 96'b0011);
      end else begin
        chk("to_expire", 96'({d_rvalid_o, d_err_o, bus_req_o, stallreq_o, d_rdata_o}),
            96'({4'b1100, 32'h0}));
      end
      nxt();
    end
    d_req_i = 1'b1; d_addr_i = 32'h600;
    settle();
    chk("to_idle_again", 96'({d_gnt_o, bus_req_o}), 96'b10);
    nxt();
    // Timeout race: response on the expiry cycle wins.
    d_req_i = 1'b0; bus_gnt_i = 1'b1;
    nxt();
    bus_gnt_i = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      if (k == 16) begin bus_rvalid_i = 1'b1; bus_rdata_i = 32'h1234; end
      settle();
      if (k < 16) chk($sformatf("race_wait%0d", k), 96'(d_rvalid_o), 96'h0);
      else chk("race_expire", 96'({d_rvalid_o, d_err_o, d_rdata_o}), 96'({2'b10, 32'h1234}));
      nxt();
    end
    clr_inputs();

    // Reset during REQ drops bus_req immediately.
    d_req_i = 1'b1; d_addr_i = 32'h700;
    nxt();
    d_req_i = 1'b0;
    settle();
    chk("rst_req_pre", 96'(bus_req_o), 96'h1);
    rst_n_i = 1'b0;
    #1;
    chk("rst_req_now", 96'({bus_req_o, bus_addr_o}), 96'h0);
    do_reset();

    // Reset during RESP while the slave is answering.
    d_req_i = 1'b1; d_addr_i = 32'h800;
    nxt();
    bus_gnt_i = 1'b1;
    nxt();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hAA;
    settle();
    chk("rst_resp_pre", 96'({d_rvalid_o, d_rdata_o}), 96'({1'b1, 32'hAA}));
    rst_n_i = 1'b0;
    #1;
    chk("rst_resp_now", 96'(outs()), 96'h0);
    @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
    d_req_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk($sformatf("rst_late_rv%0d", k), 96'(outs()), 96'h0);
      nxt();
    end
    do_reset();

    // Collision with the data requester dropping after its grant.
    for (int k = 0; k < 4; k++) begin
      d_req_i = 1'b1; i_req_i = 1'b1; d_addr_i = 32'h1000 + 32'(k);
      settle();
      chk($sformatf("col%0d_first", k), 96'({d_gnt_o, i_gnt_o}), 96'b10);
      nxt();
      d_req_i = 1'b0; bus_gnt_i = 1'b1;
      settle();
      chk($sformatf("col%0d_busy", k), 96'(i_gnt_o), 96'h0);
      nxt();
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1;
      nxt();
      bus_rvalid_i = 1'b0;
      settle();
      chk($sformatf("col%0d_fetch", k), 96'({d_gnt_o, i_gnt_o}), 96'b01);
      nxt();
      i_req_i = 1'b0; bus_gnt_i = 1'b1;
      nxt();
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h13 + 32'(k);
      settle();
      chk($sformatf("col%0d_irv", k), 96'({i_rvalid_o, i_rdata_o}), 96'({1'b1, 32'h13 + 32'(k)}));
      nxt();
      clr_inputs();
    end
    do_reset();

    // Both requesters held high across four back-to-back transactions.
    d_req_i = 1'b1; i_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] exp_g;
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_g = 2'b10;
`endif
      settle();
      chk($sformatf("hold%0d_grant", k), 96'({d_gnt_o, i_gnt_o}), 96'(exp_g));
      nxt();
      bus_gnt_i = 1'b1;
      nxt();
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1;
      nxt();
      bus_rvalid_i = 1'b0;
    end
    do_reset();

    run_random(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the core's single memory bus between instruction fetch (IF) and the data load/store path driven by the exe stage's mem_op/mem_addr/mem_data outputs.
- Captures one request at a time, runs it on the bus, and routes the response back to its owner.
- Raises stallreq_o to the pipeline controller while a data access is pending.
- Drops fetch responses that a taken jump or branch has made stale.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT_CYCLES, 16, cycles from capture to abort if the bus never returns rvalid (must be ≥2)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset
d_req_i  in  1  data request
d_we_i  in  1  data write enable
d_addr_i  in  ADDR_W  data address
d_wdata_i  in  DATA_W  store data
d_be_i  in  4  byte enables (SB/SH/SW)
d_gnt_o  out  1  data request captured (1-cycle pulse)
d_rvalid_o  out  1  data response valid
d_rdata_o  out  DATA_W  load data
d_err_o  out  1  data access timed out
i_req_i  in  1  fetch request
i_addr_i  in  ADDR_W  fetch address
i_flush_i  in  1  jump taken; discard the outstanding fetch response
i_gnt_o  out  1  fetch captured (1-cycle pulse)
i_rvalid_o  out  1  fetch response valid
i_rdata_o  out  DATA_W  instruction word
i_err_o  out  1  fetch timed out
bus_req_o  out  1  bus request
bus_we_o  out  1  bus write
bus_addr_o  out  ADDR_W  bus address
bus_wdata_o  out  DATA_W  bus write data
bus_be_o  out  4  bus byte enables
bus_gnt_i  in  1  slave accepted the request
bus_rvalid_i  in  1  slave response valid
bus_rdata_i  in  DATA_W  slave read data
stallreq_o  out  1  data path must stall

Behaviour:
- Interface: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset: state IDLE, owner DATA, last-granted FETCH, timer 0. Every output and every bus_* register is 0, taking effect immediately on assertion.
- Reset mid-transaction abandons the transaction. No response is delivered.
- States:
  - IDLE: no transaction in flight.
  - REQ: bus_req_o=1, waiting for bus_gnt_i.
  - RESP: bus_req_o=0, waiting for bus_rvalid_i.
- IDLE accept and priority:
  - d_req_i has fixed priority over i_req_i.
  - On accept, pulse the winner's *_gnt_o for one cycle.
  - In the same cycle, register addr, wdata, we and be into the bus_* registers. Fetches use we=0, be=4'hF.
  - Set owner and go to REQ.
  - The master may drop or change its request after the gnt pulse.
- REQ: on bus_gnt_i go to RESP. bus_* stays stable until then.
- RESP: on bus_rvalid_i, in the same cycle:
  - assert owner *_rvalid_o=1;
  - drive *_rdata_o=bus_rdata_i, combinational pass-through;
  - go to IDLE.
  - Non-owner rvalid, and both rdata outputs outside a valid cycle, are 0.
- Back-to-back: the earliest next capture is the cycle after the return to IDLE. Minimum transaction is 3 cycles: capture, gnt, rvalid.
- Timeout:
  - The timer clears on capture and counts every cycle in REQ and RESP.
  - On reaching TIMEOUT_CYCLES with no rvalid, pulse owner *_rvalid_o=1 and *_err_o=1 with rdata=0, deassert bus_req_o, and go to IDLE.
  - A bus_rvalid_i in the same cycle wins. Response is normal, err=0.
- Flush:
  - i_flush_i while owner=FETCH in REQ or RESP sets a sticky drop flag.
  - The bus transaction still completes or times out, but i_rvalid_o and i_err_o are suppressed.
  - The flag clears on the return to IDLE.
  - i_flush_i in IDLE has no effect.
- stallreq_o = (d_req_i && !d_gnt_o) || (state!=IDLE && owner==DATA && !d_rvalid_o). Combinational.
- Writes still return an rvalid pulse (rdata ignored), so stores complete explicitly.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both d_req_i and i_req_i are high in IDLE, grant the master not granted last. A lone requester is always granted. last-granted updates on every capture.
- Undefined: fixed data priority, and the last-granted register is not built.

Decomposition:
- Shared defines header holds:
  - state encodings ARB_IDLE/ARB_REQ/ARB_RESP (2 bits);
  - owner codes ARB_OWN_DATA/ARB_OWN_FETCH;
  - fetch byte-enable constant 4'hF.
- One sub-module, arb_timer: clear, enable, TIMEOUT_CYCLES compare, expired output, counter width $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Data-only load:
  - Stimulus: d_req=1, addr 0x100; gnt 1 cycle later; rvalid 2 cycles after gnt with rdata 0xDEADBEEF.
  - Required: d_gnt pulse at the capture cycle; d_rvalid with 0xDEADBEEF; stallreq high until the rvalid cycle, low after.
- Collision, feature off:
  - Stimulus: d_req and i_req rise together.
  - Required: data captured first; fetch captured the cycle after data completes; fetch never granted first across 4 repeats.
- Collision, ARB_ROUND_ROBIN_EN defined:
  - Stimulus: both requesters held high for 4 transactions.
  - Required: grant order alternates D,F,D,F.
- Flush:
  - Stimulus: fetch 0x200 in RESP; i_flush_i pulses; rvalid arrives with 0x13.
  - Required: i_rvalid_o stays 0; next fetch 0x300 returns normally.
- Timeout, TIMEOUT_CYCLES=16:
  - Stimulus: bus_gnt never asserted.
  - Required: at cycle 16 after capture, d_rvalid=1, d_err=1, d_rdata=0, bus_req drops, state IDLE.
  - Repeat with rvalid on the expiry cycle: normal response, d_err=0.
- Reset mid-transaction:
  - Stimulus: rst_n_i low during RESP.
  - Required: bus_req_o and all outputs 0 immediately; a late bus_rvalid_i after release produces no response.
